multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle successor to the single-cycle MIPS main controller. It keeps the same instruction set and control-signal encodings, but sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. Memory accesses use a ready handshake, unsupported encodings are flagged, and retired instructions are counted. It sits between the instruction register and the multi-cycle datapath: PC, IR, register file, ALU, extender and unified memory.

## Interface
Parameters:
- ALUOP_W, 5, width of Aluctrl; codes are the `ALUOp_*` values from ctrl_encode_def.v.
- EXT_W, 2, width of ExtOp; codes are `EXT_ZERO`, `EXT_SIGNED`, `EXT_HIGHPOS`.
- MEM_WAIT_EN, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- OpCode  in  6  IR[31:26]; valid from the DECODE cycle onward.
- funct  in  6  IR[5:0].
- cond  in  1  ALU branch-condition result (EQL/BNE true).
- mem_ready  in  1  memory completes the current request this cycle.
- pc_we  out  1  PC write strobe.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- ir_we  out  1  IR write strobe.
- mem_req  out  1  memory request.
- MemR  out  1  read qualifier.
- MemW  out  1  write qualifier.
- RegW  out  1  register file write.
- RegDst  out  1  1 = rd, 0 = rt.
- Mem2R  out  1  write-back source is memory.
- Alusrc  out  1  ALU B operand is immediate/shamt.
- ExtOp  out  EXT_W  extender mode.
- Aluctrl  out  ALUOP_W  ALU operation.
- illegal  out  1  one-cycle pulse on an unsupported encoding.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- instr_cnt  out  CNT_W  retired-instruction count.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

## Operation
- Supported: R-type addu/subu/add/sub/and/or/sll/srl/slt, plus ori, lw, sw, beq, bne, lui, j, slti.
- Per-instruction RegDst/Alusrc/ExtOp/Aluctrl values are identical to the single-cycle controller.
- Internal op_q/fn_q registers load OpCode/funct in DECODE. EXEC, MEM and WB decode from op_q/fn_q only.
- FETCH: mem_req=1, MemR=1. While mem_ready=0, stay in FETCH. On mem_ready=1: ir_we=1, pc_we=1, pc_src=0, go to DECODE.
- DECODE, unsupported OpCode or funct: illegal=1, instr_done=1, go to FETCH.
- DECODE, j: pc_we=1, pc_src=2, instr_done=1, go to FETCH.
- DECODE, all other instructions: go to EXEC.
- EXEC: Alusrc/ExtOp/Aluctrl are driven.
  - beq/bne: pc_we=cond, pc_src=1, instr_done=1, go to FETCH.
  - lw/sw: go to MEM.
  - everything else: go to WB.
- MEM: mem_req=1, with MemR=1 for lw or MemW=1 for sw. Aluctrl stays `ALUOp_ADD` and ExtOp stays `EXT_SIGNED`. Wait for mem_ready.
  - sw on ready: instr_done=1, go to FETCH.
  - lw on ready: go to WB.
- WB: RegW=1, RegDst per op_q/fn_q, Mem2R=1 only for lw, instr_done=1, go to FETCH.
- Undriven outputs in any state are 0; ExtOp=`EXT_ZERO`, Aluctrl=`ALUOp_ADD`.
- instr_cnt increments by 1 on every cycle with instr_done=1, including illegal instructions. It wraps from 2^CNT_W-1 to 0.
- Unused state encodings 5-7 go to FETCH on the next edge with all strobes 0.

## Timing
- rst=1 at an edge: state=FETCH, op_q=fn_q=0, instr_cnt=0.
- While rst=1, all strobes (pc_we, ir_we, mem_req, MemR, MemW, RegW, illegal, instr_done) are forced to 0. Mux selects take their idle values.
- Reset mid-instruction, including mid-MEM with mem_ready pending: the instruction is abandoned and is not counted. The first cycle after rst falls is FETCH.
- Outputs are combinational from state, op_q/fn_q (OpCode/funct in DECODE), cond and mem_ready. Strobes are Mealy on mem_ready in FETCH and MEM.
- Cycles per instruction with zero wait states: R-type/ori/lui/slti 4, lw 5, sw 4, beq/bne 3, j 2, illegal 2.
- Each cycle with mem_ready=0 in FETCH or MEM adds 1 cycle. mem_req stays asserted and is stable throughout the stall.
- With MEM_WAIT_EN=0, FETCH and MEM always take exactly 1 cycle.
- A new instruction's FETCH starts on the edge after instr_done.

## Test plan
- Reset, then add (funct 100000) with mem_ready tied 1 -> states 0,1,2,4. WB cycle has RegW=1, RegDst=1, Aluctrl=`ALUOp_ADD` in EXEC. instr_cnt=1 after 4 cycles.
- lw with mem_ready low for 2 cycles in both FETCH and MEM -> 9 cycles total. mem_req held high through the stalls. WB has Mem2R=1, RegW=1. ExtOp=`EXT_SIGNED` in EXEC and MEM.
- beq with cond=1, then bne with cond=0 -> first instruction pc_we=1, pc_src=1 in EXEC; second pc_we=0. Each takes 3 cycles. instr_cnt increments by 2 in total.
- j, then OpCode 111111 -> j gives pc_we=1, pc_src=2 in DECODE. The invalid opcode gives illegal=1 for exactly one cycle. No RegW or MemW in either.
- rst asserted during a lw MEM stall -> next cycle state=FETCH, instr_cnt=0, no RegW pulse.
- CNT_W=4: retire 17 instructions -> instr_cnt reads 15, then 0, then 1. With MEM_WAIT_EN=0, sw with mem_ready=0 still completes in 4 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXEC/MEM/WB with a
// memory ready handshake, flags unsupported encodings and counts retired instructions.
module multicycle_ctrl #(
  parameter int ALUOP_W     = 5,
  parameter int EXT_W       = 2,
  parameter int MEM_WAIT_EN = 1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         funct,
  input  logic               cond,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               ir_we,
  output logic               mem_req,
  output logic               MemR,
  output logic               MemW,
  output logic               RegW,
  output logic               RegDst,
  output logic               Mem2R,
  output logic               Alusrc,
  output logic [EXT_W-1:0]   ExtOp,
  output logic [ALUOP_W-1:0] Aluctrl,
  output logic               illegal,
  output logic               instr_done,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [2:0]         state
);

  localparam logic [ALUOP_W-1:0] ALUOP_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALUOP_ADDU = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALUOP_SUBU = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALUOP_AND  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALUOP_OR   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALUOP_SLL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALUOP_SRL  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALUOP_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALUOP_EQL  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALUOP_BNE  = ALUOP_W'(10);

  localparam logic [EXT_W-1:0] EXT_ZERO    = EXT_W'(0);
  localparam logic [EXT_W-1:0] EXT_SIGNED  = EXT_W'(1);
  localparam logic [EXT_W-1:0] EXT_HIGHPOS = EXT_W'(2);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t cur, nxt;
  logic [5:0] op_q, fn_q;
  logic [5:0] op_sel, fn_sel;
  logic       ready;

  logic               dec_legal, dec_j, dec_br, dec_lw, dec_sw;
  logic               dec_regdst, dec_alusrc;
  logic [EXT_W-1:0]   dec_ext;
  logic [ALUOP_W-1:0] dec_alu;

  assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state = cur;

  // DECODE looks at the live IR fields; later states use the captured copies.
  assign op_sel = (cur == S_DECODE) ? OpCode : op_q;
  assign fn_sel = (cur == S_DECODE) ? funct  : fn_q;

  always_comb begin
    dec_legal  = 1'b1;
    dec_j      = 1'b0;
    dec_br     = 1'b0;
    dec_lw     = 1'b0;
    dec_sw     = 1'b0;
    dec_regdst = 1'b0;
    dec_alusrc = 1'b0;
    dec_ext    = EXT_ZERO;
    dec_alu    = ALUOP_ADD;
    case (op_sel)
      OP_RTYPE: begin
        dec_regdst = 1'b1;
        case (fn_sel)
          6'h21:   dec_alu = ALUOP_ADDU;
          6'h23:   dec_alu = ALUOP_SUBU;
          6'h20:   dec_alu = ALUOP_ADD;
          6'h22:   dec_alu = ALUOP_SUB;
          6'h24:   dec_alu = ALUOP_AND;
          6'h25:   dec_alu = ALUOP_OR;
          6'h00:   begin dec_alu = ALUOP_SLL; dec_alusrc = 1'b1; end
          6'h02:   begin dec_alu = ALUOP_SRL; dec_alusrc = 1'b1; end
          6'h2a:   dec_alu = ALUOP_SLT;
          default: begin dec_legal = 1'b0; dec_regdst = 1'b0; end
        endcase
      end
      OP_ORI:  begin dec_alusrc = 1'b1; dec_alu = ALUOP_OR; end
      OP_LW:   begin dec_lw = 1'b1; dec_alusrc = 1'b1; dec_ext = EXT_SIGNED; end
      OP_SW:   begin dec_sw = 1'b1; dec_alusrc = 1'b1; dec_ext = EXT_SIGNED; end
      OP_BEQ:  begin dec_br = 1'b1; dec_ext = EXT_SIGNED; dec_alu = ALUOP_EQL; end
      OP_BNE:  begin dec_br = 1'b1; dec_ext = EXT_SIGNED; dec_alu = ALUOP_BNE; end
      OP_LUI:  begin dec_alusrc = 1'b1; dec_ext = EXT_HIGHPOS; end
      OP_J:    dec_j = 1'b1;
      OP_SLTI: begin dec_alusrc = 1'b1; dec_ext = EXT_SIGNED; dec_alu = ALUOP_SLT; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt        = S_FETCH;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    ir_we      = 1'b0;
    mem_req    = 1'b0;
    MemR       = 1'b0;
    MemW       = 1'b0;
    RegW       = 1'b0;
    RegDst     = 1'b0;
    Mem2R      = 1'b0;
    Alusrc     = 1'b0;
    ExtOp      = EXT_ZERO;
    Aluctrl    = ALUOP_ADD;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        MemR    = 1'b1;
        if (ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end else if (dec_j) begin
          pc_we      = 1'b1;
          pc_src     = 2'd2;
          instr_done = 1'b1;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        Alusrc  = dec_alusrc;
        ExtOp   = dec_ext;
        Aluctrl = dec_alu;
        if (dec_br) begin
          pc_we      = cond;
          pc_src     = 2'd1;
          instr_done = 1'b1;
        end else if (dec_lw || dec_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        MemR    = dec_lw;
        MemW    = dec_sw;
        ExtOp   = EXT_SIGNED;
        if (!ready)      nxt = S_MEM;
        else if (dec_lw) nxt = S_WB;
        else             instr_done = 1'b1;
      end
      S_WB: begin
        RegW       = 1'b1;
        RegDst     = dec_regdst;
        Mem2R      = dec_lw;
        instr_done = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
    if (rst) begin
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      ir_we      = 1'b0;
      mem_req    = 1'b0;
      MemR       = 1'b0;
      MemW       = 1'b0;
      RegW       = 1'b0;
      RegDst     = 1'b0;
      Mem2R      = 1'b0;
      Alusrc     = 1'b0;
      ExtOp      = EXT_ZERO;
      Aluctrl    = ALUOP_ADD;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      instr_cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        op_q <= OpCode;
        fn_q <= funct;
      end
      if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule
